// File: rtl/led_seq_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg
// Shared definitions for the LED pattern sequencer:
//   MODE_W   - width of the pattern-mode field
//   mode_t   - pattern modes in button-cycle order
//   seed_lsb - bit 0 of the seed pattern loaded when a mode becomes current
//              (all higher seed bits are zero for every mode)
// -----------------------------------------------------------------------------
package led_seq_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_BAR    = 2'd3
  } mode_t;

  // BOUNCE and ROTATE start from a single lit LSB; COUNT and BAR start dark.
  function automatic logic seed_lsb(input mode_t m);
    return (m == MODE_BOUNCE) || (m == MODE_ROTATE);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Turns a raw, asynchronous push-button pin into single-cycle press events.
// The pin is brought into the clock domain by a two-flop synchroniser; a new
// level is accepted only after it has differed from the accepted level for
// DEBOUNCE_CYCLES consecutive cycles. An accepted rising level yields one
// event. From a clean edge, the event is seen 2 + DEBOUNCE_CYCLES cycles later.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive stable cycles needed to accept a level (>= 1)
// Ports:
//   i_clk   in  1  system clock
//   i_reset in  1  asynchronous active-low reset
//   i_btn   in  1  raw button pin
//   o_event out 1  one-cycle press event (debounced rising edge)
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_event
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             differ;
  logic             accept;

  assign differ  = (sync2_reg != stable_reg);
  // The level has differed for DEBOUNCE_CYCLES cycles counting this one.
  assign accept  = differ && (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign o_event = accept && sync2_reg;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= i_btn;
      sync2_reg <= sync1_reg;
      if (accept) begin
        stable_reg <= sync2_reg;
        cnt_reg    <= '0;
      end else if (differ) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end else begin
        // Any return to the accepted level restarts the stability window.
        cnt_reg <= '0;
      end
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// led_pattern_sequencer
// LED pattern generator with a built-in step divider and four patterns
// (BOUNCE, ROTATE, COUNT, BAR) cycled by a button.
//
// Build option: define LED_SEQ_DEBOUNCE_EN to treat i_btn as a raw button pin
// (synchroniser + debounce, one event per debounced press). Without it, i_btn
// is a synchronous strobe and every high cycle is one event.
//
// Parameters:
//   WIDTH           - number of LEDs (>= 2)
//   TICK_DIV        - clock cycles per pattern step (>= 1)
//   DEBOUNCE_CYCLES - debounce stability window (LED_SEQ_DEBOUNCE_EN only)
// Ports:
//   i_clk    in  1      system clock
//   i_reset  in  1      asynchronous active-low reset
//   i_enable in  1      high: divider runs; low: divider and pattern hold
//   i_btn    in  1      mode-advance input
//   o_led    out WIDTH  LED drive, bit 0 = LSB LED
//   o_step   out 1      one-cycle pulse in the cycle o_led updates
//   o_mode   out 2      current pattern
// -----------------------------------------------------------------------------
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int TICK_DIV        = 25000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_btn,
  output logic [WIDTH-1:0]  o_led,
  output logic              o_step,
  output logic [MODE_W-1:0] o_mode
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_reg;
  logic             step_reg;
  logic [WIDTH-1:0] led_reg;
  mode_t            mode_reg;
  mode_t            pending_reg;
  logic             dir_up_reg;
  logic             fill_reg;

  logic             btn_event;
  logic             step_fire;
  logic [WIDTH-1:0] led_next;
  logic             dir_up_next;
  logic             fill_next;

  // ---------------------------------------------------------------------------
  // Mode-advance events
  // ---------------------------------------------------------------------------
`ifdef LED_SEQ_DEBOUNCE_EN
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_btn  (i_btn),
    .o_event(btn_event)
  );
`else
  assign btn_event = i_btn;
`endif

  // The step edge is the one that ends the last divider cycle.
  assign step_fire = i_enable && (cnt_reg == CNT_W'(TICK_DIV - 1));

  // ---------------------------------------------------------------------------
  // Pattern datapath: next pattern value for the current mode
  // ---------------------------------------------------------------------------
  always_comb begin
    led_next    = led_reg;
    dir_up_next = dir_up_reg;
    fill_next   = fill_reg;
    case (mode_reg)
      MODE_BOUNCE: begin
        // Reverse on reaching an end so the end LED is lit for one step only.
        if (dir_up_reg) begin
          if (led_reg[WIDTH-1]) begin
            led_next    = led_reg >> 1;
            dir_up_next = 1'b0;
          end else begin
            led_next = led_reg << 1;
          end
        end else begin
          if (led_reg[0]) begin
            led_next    = led_reg << 1;
            dir_up_next = 1'b1;
          end else begin
            led_next = led_reg >> 1;
          end
        end
      end
      MODE_ROTATE: led_next = {led_reg[WIDTH-2:0], led_reg[WIDTH-1]};
      MODE_COUNT:  led_next = led_reg + WIDTH'(1);
      MODE_BAR: begin
        led_next = {led_reg[WIDTH-2:0], fill_reg};
        // Phase flips as the bar reaches full (fill) or empty (drain).
        if (fill_reg && (&led_next)) begin
          fill_next = 1'b0;
        end else if (!fill_reg && (led_next == '0)) begin
          fill_next = 1'b1;
        end
      end
      default: led_next = led_reg;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Divider, mode registers and pattern state
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_reg     <= '0;
      step_reg    <= 1'b0;
      led_reg     <= WIDTH'(1);
      mode_reg    <= MODE_BOUNCE;
      pending_reg <= MODE_BOUNCE;
      dir_up_reg  <= 1'b1;
      fill_reg    <= 1'b1;
    end else begin
      // Events keep accumulating while the divider is held.
      if (btn_event) begin
        pending_reg <= mode_t'(pending_reg + 2'd1);
      end

      if (i_enable) begin
        cnt_reg <= step_fire ? '0 : cnt_reg + CNT_W'(1);
      end

      step_reg <= step_fire;

      if (step_fire) begin
        // pending_reg is sampled before this edge's event, so an event in the
        // step cycle lands at the following step.
        if (pending_reg != mode_reg) begin
          mode_reg   <= pending_reg;
          led_reg    <= {{(WIDTH-1){1'b0}}, seed_lsb(pending_reg)};
          dir_up_reg <= 1'b1;
          fill_reg   <= 1'b1;
        end else begin
          led_reg    <= led_next;
          dir_up_reg <= dir_up_next;
          fill_reg   <= fill_next;
        end
      end
    end
  end

  assign o_led  = led_reg;
  assign o_step = step_reg;
  assign o_mode = mode_reg;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_sequencer
// Directed bench for led_pattern_sequencer. Two instances share clock, reset
// and enable: an 8-LED one and a 4-LED one (for BAR), both stepping every 4
// cycles. Expected step results are queued when stimulus is applied and
// compared when o_step is seen. With LED_SEQ_DEBOUNCE_EN a third instance
// exercises the button debouncer.
// -----------------------------------------------------------------------------
module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       btn8;
  logic       btn4;
  logic [7:0] led8;
  logic       step8;
  logic [1:0] mode8;
  logic [3:0] led4;
  logic       step4;
  logic [1:0] mode4;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] led;
    logic [1:0] mode;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  logic [3:0] bar_tab [8];

  always #5 clk = ~clk;

  led_pattern_sequencer #(
    .WIDTH(8), .TICK_DIV(4), .DEBOUNCE_CYCLES(8)
  ) dut8 (
    .i_clk(clk), .i_reset(rst_n), .i_enable(en), .i_btn(btn8),
    .o_led(led8), .o_step(step8), .o_mode(mode8)
  );

  led_pattern_sequencer #(
    .WIDTH(4), .TICK_DIV(4), .DEBOUNCE_CYCLES(8)
  ) dut4 (
    .i_clk(clk), .i_reset(rst_n), .i_enable(en), .i_btn(btn4),
    .o_led(led4), .o_step(step4), .o_mode(mode4)
  );

`ifdef LED_SEQ_DEBOUNCE_EN
  logic       btnd;
  logic [7:0] ledd;
  logic       stepd;
  logic [1:0] moded;

  led_pattern_sequencer #(
    .WIDTH(8), .TICK_DIV(1), .DEBOUNCE_CYCLES(8)
  ) dutd (
    .i_clk(clk), .i_reset(rst_n), .i_enable(en), .i_btn(btnd),
    .o_led(ledd), .o_step(stepd), .o_mode(moded)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the next o_step, then score queued expectations.
  // period != 0 also checks the number of cycles waited.
  task automatic expect_step(input int period);
    int   c;
    exp_t e;
    c = 0;
    do begin
      tick();
      c++;
    end while (!step8 && c < 40);
    chk("step8_seen", step8, 1);
    if (period != 0) chk("step_period", c, period);
    e = q8.pop_front();
    chk("led8", led8, e.led);
    chk("mode8", mode8, e.mode);
    if (q4.size() != 0) begin
      e = q4.pop_front();
      chk("step4", step4, 1);
      chk("led4", led4, e.led);
      chk("mode4", mode4, e.mode);
    end
  endtask

  function automatic logic [7:0] bounce_exp(input int k);
    int         p;
    int         pos;
    logic [7:0] one;
    one = 8'h01;
    p   = (k + 1) % 14;
    pos = (p <= 7) ? p : 14 - p;
    return one << pos;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bar_tab = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    rst_n = 1'b0;
    en    = 1'b1;
    btn8  = 1'b0;
    btn4  = 1'b0;
`ifdef LED_SEQ_DEBOUNCE_EN
    btnd  = 1'b0;
`endif
    tick();
    tick();
    chk("rst_led8", led8, 8'h01);
    chk("rst_mode8", mode8, 2'd0);
    chk("rst_step8", step8, 1'b0);
    chk("rst_led4", led4, 4'h1);
    chk("rst_mode4", mode4, 2'd0);

    // Release; three strobes move dut4 to BAR at its first step.
    rst_n = 1'b1;
`ifndef LED_SEQ_DEBOUNCE_EN
    btn4 = 1'b1;
    tick(); tick(); tick();
    btn4 = 1'b0;
    q4.push_back('{led: 8'h00, mode: 2'd3});
`endif
    q8.push_back('{led: bounce_exp(0), mode: 2'd0});
    expect_step(0);

    // BOUNCE full period plus one, BAR alongside.
    for (int k = 1; k < 15; k++) begin
      q8.push_back('{led: bounce_exp(k), mode: 2'd0});
`ifndef LED_SEQ_DEBOUNCE_EN
      q4.push_back('{led: {4'h0, bar_tab[k % 8]}, mode: 2'd3});
`endif
      expect_step(4);
    end

`ifndef LED_SEQ_DEBOUNCE_EN
    // Two strobes before one step: mode 0 -> 2, COUNT from 0, wrap at 0xFF.
    btn8 = 1'b1;
    tick(); tick();
    btn8 = 1'b0;
    q8.push_back('{led: 8'h00, mode: 2'd2});
    expect_step(0);
    for (int v = 1; v <= 256; v++) begin
      q8.push_back('{led: 8'(v), mode: 2'd2});
      expect_step(4);
    end

    // Three strobes: 2 -> 3 -> 0 -> 1, ROTATE wraps MSB to bit 0.
    btn8 = 1'b1;
    tick(); tick(); tick();
    btn8 = 1'b0;
    q8.push_back('{led: 8'h01, mode: 2'd1});
    expect_step(0);
    for (int i = 1; i <= 8; i++) begin
      q8.push_back('{led: 8'h01 << (i % 8), mode: 2'd1});
      expect_step(4);
    end

    // Enable low for 10 cycles: nothing moves, divider resumes where it was.
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_step8", step8, 1'b0);
      chk("hold_led8", led8, 8'h01);
    end
    en = 1'b1;
    q8.push_back('{led: 8'h02, mode: 2'd1});
    expect_step(4);

    // Strobe in the cycle whose edge is a step: not applied until the next.
    tick(); tick(); tick();
    btn8 = 1'b1;
    q8.push_back('{led: 8'h04, mode: 2'd1});
    expect_step(1);
    btn8 = 1'b0;
    q8.push_back('{led: 8'h00, mode: 2'd2});
    expect_step(4);
`endif

    // Asynchronous reset between clock edges.
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_led8", led8, 8'h01);
    chk("async_mode8", mode8, 2'd0);
    chk("async_step8", step8, 1'b0);
    chk("async_led4", led4, 4'h1);
    chk("async_mode4", mode4, 2'd0);
    #1;
    rst_n = 1'b1;

`ifdef LED_SEQ_DEBOUNCE_EN
    // Short glitches are rejected, one clean press gives exactly one event.
    tick();
    for (int g = 0; g < 2; g++) begin
      btnd = 1'b1;
      tick(); tick(); tick();
      btnd = 1'b0;
      tick(); tick(); tick();
    end
    for (int i = 0; i < 12; i++) tick();
    chk("glitch_mode", moded, 2'd0);
    btnd = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("press_mode_t10", moded, 2'd0);
    tick();
    chk("press_mode_t11", moded, 2'd1);
    for (int i = 0; i < 9; i++) tick();
    btnd = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("release_mode", moded, 2'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
